// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and address-field constants for the data cache
//  Revision    : 1.0  initial release
// ============================================================================
package cache_pkg;

   // Address layout: tag [11:9], index [8:4], word [3:2], byte [1:0]
   localparam int c_ADDR_W   = 12;
   localparam int c_DATA_W   = 32;
   localparam int LINE_W     = 128;
   localparam int c_TAG_LSB  = 9;
   localparam int c_IDX_LSB  = 4;
   localparam int c_IDX_W    = 5;
   localparam int c_WORD_LSB = 2;
   localparam int c_WORD_W   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      REFILL = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_line_store
//  Description : Direct-mapped valid/tag/data storage with combinational hit
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_line_store
   import cache_pkg::*;
#(
   parameter int LINES = 32,
   parameter int TAG_W = 3
)
(
   input  logic                clk,
   input  logic                valid_clr,
   input  logic [c_IDX_W-1:0]  index,
   input  logic [TAG_W-1:0]    tag_cmp,
   output logic                hit,
   output logic [LINE_W-1:0]   line_rdata,
   input  logic                line_we,
   input  logic [LINE_W-1:0]   line_wdata,
   input  logic [TAG_W-1:0]    line_wtag,
   input  logic                word_we,
   input  logic [c_WORD_W-1:0] word_sel,
   input  logic [c_DATA_W-1:0] word_wdata
);

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [LINE_W-1:0] r_data [LINES];

   // Only the valid bits are cleared; tag and data keep stale contents
   always_ff @(posedge clk or posedge valid_clr) begin
      if (valid_clr)
         r_valid <= '0;
      else if (line_we)
         r_valid[index] <= 1'b1;
   end

   // Whole-line refill, or a single-word write-through update on a store hit
   always_ff @(posedge clk) begin
      if (line_we) begin
         r_tag[index]  <= line_wtag;
         r_data[index] <= line_wdata;
      end else if (word_we) begin
         r_data[index][{word_sel, 5'd0} +: c_DATA_W] <= word_wdata;
      end
   end

   assign hit        = r_valid[index] && (r_tag[index] == tag_cmp);
   assign line_rdata = r_data[index];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped write-through, no-write-allocate data cache
//                controller with single-line refill
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_ctrl
   import cache_pkg::*;
#(
   parameter int LINES = 32,
   parameter int TAG_W = 3
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [c_ADDR_W-1:0] cpu_addr,
   input  logic [c_DATA_W-1:0] cpu_wdata,
   input  logic                cpu_we,
   input  logic                cpu_re,
   output logic [c_DATA_W-1:0] cpu_rdata,
   output logic                cpu_stall,
   output logic [c_ADDR_W-1:0] mem_addr,
   output logic [c_DATA_W-1:0] mem_wdata,
   output logic                mem_we,
   output logic                mem_re,
   output logic                mem_hit,
   output logic                mem_miss,
   input  logic [LINE_W-1:0]   mem_rdata,
   input  logic                mem_ready
);

   state_t              r_state;
   logic                r_load;
   logic [c_WORD_W-1:0] r_word;

   logic                w_idle;
   logic                w_hit;
   logic [c_IDX_W-1:0]  w_index;
   logic [c_WORD_W-1:0] w_word_sel;
   logic [LINE_W-1:0]   w_line;
   logic [c_DATA_W-1:0] w_word;
   logic                w_line_we;
   logic                w_word_we;

   assign w_idle = (r_state == IDLE);

   // In IDLE the CPU address selects the line; otherwise the captured one does,
   // so CPU input changes cannot disturb an in-flight transaction
   assign w_index    = w_idle ? cpu_addr[c_IDX_LSB +: c_IDX_W]
                              : mem_addr[c_IDX_LSB +: c_IDX_W];
   assign w_word_sel = w_idle ? cpu_addr[c_WORD_LSB +: c_WORD_W] : r_word;

   assign w_line_we = (r_state == REFILL) && mem_ready;
   assign w_word_we = (r_state == WRITE) && mem_ready && mem_hit;

   dcache_line_store #(
      .LINES (LINES),
      .TAG_W (TAG_W)
   ) u_store (
      .clk        (clk),
      .valid_clr  (reset),
      .index      (w_index),
      .tag_cmp    (cpu_addr[c_TAG_LSB +: TAG_W]),
      .hit        (w_hit),
      .line_rdata (w_line),
      .line_we    (w_line_we),
      .line_wdata (mem_rdata),
      .line_wtag  (mem_addr[c_TAG_LSB +: TAG_W]),
      .word_we    (w_word_we),
      .word_sel   (mem_addr[c_WORD_LSB +: c_WORD_W]),
      .word_wdata (mem_wdata)
   );

   assign w_word = w_line[{w_word_sel, 5'd0} +: c_DATA_W];

   // Stall from the launch cycle (stores and load misses) until DONE
   assign cpu_stall = !reset &&
                      ((w_idle && (cpu_we || (cpu_re && !w_hit))) ||
                       (r_state == WRITE) || (r_state == REFILL));

   // Load data: zero-latency on an IDLE hit, or the refilled word in DONE
   assign cpu_rdata = ((!reset && w_idle && cpu_re && !cpu_we && w_hit) ||
                       ((r_state == DONE) && r_load)) ? w_word : '0;

   // Transaction FSM with registered memory-side address, data and strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_load    <= 1'b0;
         r_word    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_hit   <= 1'b0;
         mem_miss  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cpu_we) begin
                  r_state   <= WRITE;
                  r_load    <= 1'b0;
                  r_word    <= cpu_addr[c_WORD_LSB +: c_WORD_W];
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
                  mem_we    <= 1'b1;
                  mem_hit   <= w_hit;
                  mem_miss  <= !w_hit;
               end else if (cpu_re && !w_hit) begin
                  r_state  <= REFILL;
                  r_load   <= 1'b1;
                  r_word   <= cpu_addr[c_WORD_LSB +: c_WORD_W];
                  mem_addr <= {cpu_addr[c_ADDR_W-1:c_IDX_LSB], {c_IDX_LSB{1'b0}}};
                  mem_re   <= 1'b1;
                  mem_hit  <= 1'b0;
                  mem_miss <= 1'b1;
               end
            end
            WRITE, REFILL: begin
               if (mem_ready) begin
                  r_state  <= DONE;
                  mem_we   <= 1'b0;
                  mem_re   <= 1'b0;
                  mem_hit  <= 1'b0;
                  mem_miss <= 1'b0;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Self-checking bench for dcache_ctrl with a behavioural model
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic [11:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic         cpu_we;
   logic         cpu_re;
   logic [31:0]  cpu_rdata;
   logic         cpu_stall;
   logic [11:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_we;
   logic         mem_re;
   logic         mem_hit;
   logic         mem_miss;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   dcache_ctrl #(
      .LINES (32),
      .TAG_W (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we    (cpu_we),
      .cpu_re    (cpu_re),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_hit   (mem_hit),
      .mem_miss  (mem_miss),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   // Memory device: done pulse in the 4th cycle a strobe is held
   logic [31:0] dev_mem [1024];
   int          busy_cnt = 0;
   logic        force_ready = 1'b0;

   assign mem_ready = ((mem_re || mem_we) && busy_cnt == 3) || force_ready;

   always_comb begin
      mem_rdata = {dev_mem[{mem_addr[11:4], 2'd3}], dev_mem[{mem_addr[11:4], 2'd2}],
                   dev_mem[{mem_addr[11:4], 2'd1}], dev_mem[{mem_addr[11:4], 2'd0}]};
   end

   always @(posedge clk) begin
      if (mem_re || mem_we) busy_cnt <= busy_cnt + 1;
      else                  busy_cnt <= 0;
      if (mem_we && mem_ready) dev_mem[mem_addr[11:2]] <= mem_wdata;
   end

   // Reference model: cache contents and memory image
   logic        ref_valid [32];
   logic [2:0]  ref_tag   [32];
   logic [31:0] ref_data  [32][4];
   logic [31:0] ref_mem   [1024];

   int          exp_stalls;
   logic        exp_re, exp_we, exp_hit, exp_miss;
   logic [11:0] exp_addr;
   logic [31:0] exp_wdata, exp_rd;

   int          obs_stalls;
   logic        obs_re, obs_we, obs_hit, obs_miss, obs_tail, obs_timeout;
   logic [11:0] obs_addr;
   logic [31:0] obs_wdata, obs_rd;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
   endtask

   // Predicts one access and updates the model state
   task automatic model_op(input logic we, input logic re, input logic [11:0] a,
                           input logic [31:0] d);
      int   idx;
      int   w;
      logic h;
      idx = int'(a[8:4]);
      w   = int'(a[3:2]);
      h   = ref_valid[idx] && (ref_tag[idx] == a[11:9]);
      exp_stalls = 0; exp_re = 0; exp_we = 0; exp_hit = 0; exp_miss = 0;
      exp_addr = '0; exp_wdata = '0; exp_rd = '0;
      if (we) begin
         exp_stalls = 5; exp_we = 1; exp_addr = a; exp_wdata = d;
         exp_hit = h; exp_miss = !h;
         ref_mem[a[11:2]] = d;
         if (h) ref_data[idx][w] = d;
      end else if (re) begin
         if (!h) begin
            exp_stalls = 5; exp_re = 1; exp_miss = 1;
            exp_addr = {a[11:4], 4'h0};
            for (int k = 0; k < 4; k++) ref_data[idx][k] = ref_mem[a[11:4] * 4 + k];
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[11:9];
         end
         exp_rd = ref_data[idx][w];
      end
   endtask

   // Drives one access and records what the DUT did, scrambling CPU inputs
   // once the transaction is in flight
   task automatic access(input logic we, input logic re, input logic [11:0] a,
                         input logic [31:0] d);
      bit done;
      done = 0;
      obs_stalls = 0; obs_re = 0; obs_we = 0; obs_hit = 0; obs_miss = 0;
      obs_addr = '0; obs_wdata = '0; obs_rd = '0; obs_tail = 0;
      @(posedge clk); #1;
      cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            obs_rd   = cpu_rdata;
            obs_tail = mem_re | mem_we | mem_hit | mem_miss;
            done     = 1;
         end else begin
            obs_stalls++;
            if (mem_re) obs_re = 1;
            if (mem_we) obs_we = 1;
            if (mem_re || mem_we) begin
               obs_addr = mem_addr; obs_wdata = mem_wdata;
               obs_hit = mem_hit; obs_miss = mem_miss;
            end
            if (i >= 1) begin
               cpu_addr  = 12'($urandom);
               cpu_wdata = $urandom;
            end
         end
      end
      obs_timeout = !done;
      @(posedge clk); #1;
      cpu_we = 0; cpu_re = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", cpu_stall); else passed++;
      total++; if ({mem_re, mem_we, mem_hit, mem_miss} !== 4'b0)
         $display("FAIL reset_strobes: got %b want 0000", {mem_re, mem_we, mem_hit, mem_miss}); else passed++;
      total++; if (mem_addr !== 12'h0) $display("FAIL reset_mem_addr: got %h want 000", mem_addr); else passed++;
      total++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else passed++;
      total++; if (cpu_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", cpu_rdata); else passed++;
      // A stray done pulse in IDLE must not start anything
      @(posedge clk); #1; force_ready = 1'b1;
      @(posedge clk); #1; force_ready = 1'b0;
      @(negedge clk);
      total++; if ({cpu_stall, mem_re, mem_we} !== 3'b0)
         $display("FAIL idle_ready_ignored: got %b want 000", {cpu_stall, mem_re, mem_we}); else passed++;
   endtask

   task automatic test_cold_load();
      dev_mem[12'h010 >> 2] = 32'h11223344;
      ref_mem[12'h010 >> 2] = 32'h11223344;
      model_op(0, 1, 12'h010, 0);
      access(0, 1, 12'h010, 0);
      total++; if (obs_stalls != 5) $display("FAIL cold_stall: got %0d want 5", obs_stalls); else passed++;
      total++; if (obs_re !== 1'b1 || obs_addr !== 12'h010)
         $display("FAIL cold_mem_re: got re=%b addr=%h want re=1 addr=010", obs_re, obs_addr); else passed++;
      total++; if (obs_rd !== 32'h11223344) $display("FAIL cold_rdata: got %h want 11223344", obs_rd); else passed++;
      total++; if (obs_tail !== 1'b0) $display("FAIL cold_done_strobes: got %b want 0", obs_tail); else passed++;
      model_op(0, 1, 12'h010, 0);
      access(0, 1, 12'h010, 0);
      total++; if (obs_stalls != 0 || obs_re !== 1'b0)
         $display("FAIL repeat_hit: got stalls=%0d re=%b want 0 0", obs_stalls, obs_re); else passed++;
      total++; if (obs_rd !== 32'h11223344) $display("FAIL repeat_rdata: got %h want 11223344", obs_rd); else passed++;
   endtask

   task automatic test_store_hit();
      model_op(1, 0, 12'h014, 32'hDEADBEEF);
      access(1, 0, 12'h014, 32'hDEADBEEF);
      total++; if (obs_we !== 1'b1 || obs_hit !== 1'b1 || obs_miss !== 1'b0)
         $display("FAIL st_hit_flags: got we=%b hit=%b miss=%b want 1 1 0", obs_we, obs_hit, obs_miss); else passed++;
      total++; if (obs_addr !== 12'h014 || obs_wdata !== 32'hDEADBEEF)
         $display("FAIL st_hit_bus: got %h/%h want 014/deadbeef", obs_addr, obs_wdata); else passed++;
      total++; if (dev_mem[12'h014 >> 2] !== 32'hDEADBEEF)
         $display("FAIL st_hit_memory: got %h want deadbeef", dev_mem[12'h014 >> 2]); else passed++;
      model_op(0, 1, 12'h014, 0);
      access(0, 1, 12'h014, 0);
      total++; if (obs_stalls != 0 || obs_rd !== 32'hDEADBEEF)
         $display("FAIL st_hit_reload: got stalls=%0d rd=%h want 0 deadbeef", obs_stalls, obs_rd); else passed++;
   endtask

   task automatic test_store_miss();
      model_op(1, 0, 12'h200, 32'h0000000A);
      access(1, 0, 12'h200, 32'h0000000A);
      total++; if (obs_miss !== 1'b1 || obs_hit !== 1'b0 || obs_re !== 1'b0)
         $display("FAIL st_miss_flags: got miss=%b hit=%b re=%b want 1 0 0", obs_miss, obs_hit, obs_re); else passed++;
      model_op(0, 1, 12'h200, 0);
      access(0, 1, 12'h200, 0);
      total++; if (obs_stalls != 5 || obs_re !== 1'b1)
         $display("FAIL st_miss_no_alloc: got stalls=%0d re=%b want 5 1", obs_stalls, obs_re); else passed++;
      total++; if (obs_rd !== 32'h0000000A) $display("FAIL st_miss_reload: got %h want 0000000a", obs_rd); else passed++;
   endtask

   task automatic test_conflict();
      logic [11:0] seq [3];
      seq[0] = 12'h010; seq[1] = 12'h210; seq[2] = 12'h010;
      for (int i = 0; i < 3; i++) begin
         model_op(0, 1, seq[i], 0);
         access(0, 1, seq[i], 0);
         total++; if (obs_stalls != exp_stalls || obs_rd !== exp_rd)
            $display("FAIL conflict_%0d: got stalls=%0d rd=%h want %0d %h", i, obs_stalls, obs_rd, exp_stalls, exp_rd);
         else passed++;
      end
      total++; if (exp_stalls != 5) $display("FAIL conflict_model: got %0d want 5", exp_stalls); else passed++;
   endtask

   task automatic test_reset_abort();
      @(posedge clk); #1;
      cpu_re = 1; cpu_we = 0; cpu_addr = 12'h410;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1; cpu_re = 0;
      @(negedge clk);
      total++; if ({cpu_stall, mem_re, mem_we, mem_hit, mem_miss} !== 5'b0)
         $display("FAIL abort_outputs: got %b want 00000", {cpu_stall, mem_re, mem_we, mem_hit, mem_miss}); else passed++;
      @(posedge clk); #1;
      reset = 0;
      model_clear();
      model_op(0, 1, 12'h010, 0);
      access(0, 1, 12'h010, 0);
      total++; if (obs_stalls != 5 || obs_re !== 1'b1 || obs_rd !== exp_rd)
         $display("FAIL abort_reload: got stalls=%0d re=%b rd=%h want 5 1 %h", obs_stalls, obs_re, obs_rd, exp_rd);
      else passed++;
   endtask

   task automatic test_we_re_priority();
      model_op(1, 1, 12'h020, 32'hCAFE0020);
      access(1, 1, 12'h020, 32'hCAFE0020);
      total++; if (obs_we !== 1'b1 || obs_re !== 1'b0 || obs_stalls != 5)
         $display("FAIL priority: got we=%b re=%b stalls=%0d want 1 0 5", obs_we, obs_re, obs_stalls); else passed++;
      total++; if (dev_mem[12'h020 >> 2] !== 32'hCAFE0020)
         $display("FAIL priority_memory: got %h want cafe0020", dev_mem[12'h020 >> 2]); else passed++;
   endtask

   task automatic test_random();
      logic        we, re;
      logic [11:0] a;
      logic [31:0] d;
      for (int n = 0; n < 40; n++) begin
         a  = {3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom), 2'b00};
         d  = $urandom;
         we = ($urandom_range(0, 2) == 0);
         re = !we || ($urandom_range(0, 1) == 1);
         model_op(we, re, a, d);
         access(we, re, a, d);
         total++; if (obs_timeout || obs_stalls != exp_stalls)
            $display("FAIL rnd%0d_stall: got %0d want %0d", n, obs_stalls, exp_stalls); else passed++;
         total++; if ({obs_re, obs_we, obs_hit, obs_miss} !== {exp_re, exp_we, exp_hit, exp_miss})
            $display("FAIL rnd%0d_strobes: got %b want %b", n, {obs_re, obs_we, obs_hit, obs_miss},
                     {exp_re, exp_we, exp_hit, exp_miss}); else passed++;
         if (exp_re || exp_we) begin
            total++; if (obs_addr !== exp_addr)
               $display("FAIL rnd%0d_addr: got %h want %h", n, obs_addr, exp_addr); else passed++;
         end
         if (!we) begin
            total++; if (obs_rd !== exp_rd)
               $display("FAIL rnd%0d_rdata: got %h want %h", n, obs_rd, exp_rd); else passed++;
         end
         total++; if (obs_tail !== 1'b0) $display("FAIL rnd%0d_tail: got %b want 0", n, obs_tail); else passed++;
      end
   endtask

   initial begin
      reset = 1; cpu_we = 0; cpu_re = 0; cpu_addr = '0; cpu_wdata = '0;
      for (int i = 0; i < 1024; i++) begin
         ref_mem[i] = $urandom;
         dev_mem[i] = ref_mem[i];
      end
      model_clear();
      @(posedge clk);
      @(posedge clk); #1;
      reset = 0;
      test_reset();
      test_cold_load();
      test_store_hit();
      test_store_miss();
      test_conflict();
      test_reset_abort();
      test_we_re_priority();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
